// File: rtl/keymgr_pkg.sv
// Shared key-manager types: the hardware sideload key bundle and the packer FSM states.
package keymgr_pkg;

    localparam int KeyWidth     = 256;
    localparam int KeyWordWidth = 32;
    localparam int NumSharesKey = 2;
    localparam int NumRegsKey   = KeyWidth / KeyWordWidth;

    typedef struct packed {
        logic                                   valid;
        logic [NumSharesKey-1:0][KeyWidth-1:0]  key;
    } hw_key_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        VALID = 2'd2,
        WIPE  = 2'd3
    } packer_state_e;

endpackage

// File: rtl/keymgr_sideload_store.sv
// Share/word indexed key register array; the flat word count selects share and word slot.
module keymgr_sideload_store
    import keymgr_pkg::*;
#(
    parameter int NumRegs   = 8,
    parameter int NumShares = 2,
    parameter int CntW      = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clr_i,
    input  logic                                 we_i,
    input  logic [CntW-1:0]                      cnt_i,
    input  logic [KeyWordWidth-1:0]              wdata_i,
    output logic [NumShares-1:0][KeyWidth-1:0]   key_o
);

    logic [NumShares-1:0][KeyWidth-1:0] key_d, key_q;

    // Word count c lands in share c / NumRegs at word slot c % NumRegs.
    always_comb begin
        key_d = key_q;
        if (clr_i) begin
            key_d = '0;
        end else if (we_i) begin
            for (int s = 0; s < NumShares; s++) begin
                for (int i = 0; i < NumRegs; i++) begin
                    if (cnt_i == CntW'(s * NumRegs + i)) begin
                        key_d[s][i*KeyWordWidth +: KeyWordWidth] = wdata_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    assign key_o = key_q;

endmodule

// File: rtl/keymgr_sideload_packer.sv
// Packs a 32-bit word stream into a two-share sideload key and holds it valid until wiped.
module keymgr_sideload_packer
    import keymgr_pkg::*;
#(
    parameter int NumRegsKey   = keymgr_pkg::NumRegsKey,
    parameter int NumSharesKey = keymgr_pkg::NumSharesKey
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic                     word_valid_i,
    output logic                     word_ready_o,
    input  logic [KeyWordWidth-1:0]  word_data_i,
    output hw_key_req_t              key_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int NumWords = NumRegsKey * NumSharesKey;
    localparam int CntW     = $clog2(NumWords);
    localparam logic [CntW-1:0] LastCnt = CntW'(NumWords - 1);

    if (NumRegsKey * KeyWordWidth != KeyWidth) begin : g_bad_regs
        $error("NumRegsKey must cover exactly one KeyWidth share");
    end
    if (NumSharesKey != keymgr_pkg::NumSharesKey) begin : g_bad_shares
        $error("NumSharesKey must match hw_key_req_t");
    end

    packer_state_e state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            err_d, err_q;
    logic            word_ready;
    logic            store_we;
    logic            store_clr;
    logic [NumSharesKey-1:0][KeyWidth-1:0] store_key;

    // clear_i wins over start_i and over a word accept in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        word_ready = 1'b0;
        store_we   = 1'b0;
        store_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = WIPE;
                end else if (start_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (clear_i) begin
                    state_d = WIPE;
                end else begin
                    word_ready = 1'b1;
                    err_d      = start_i;
                    if (word_valid_i) begin
                        store_we = 1'b1;
                        if (cnt_q == LastCnt) begin
                            state_d = VALID;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
            end
            VALID: begin
                if (clear_i) begin
                    state_d = WIPE;
                end else begin
                    err_d = start_i;
                end
            end
            WIPE: begin
                store_clr = 1'b1;
                cnt_d     = '0;
                if (clear_i) begin
                    state_d = WIPE;
                end else begin
                    state_d = IDLE;
                    err_d   = start_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    keymgr_sideload_store #(
        .NumRegs   (NumRegsKey),
        .NumShares (NumSharesKey),
        .CntW      (CntW)
    ) u_store (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (store_clr),
        .we_i    (store_we),
        .cnt_i   (cnt_q),
        .wdata_i (word_data_i),
        .key_o   (store_key)
    );

    // A partially loaded key is never visible outside VALID.
    always_comb begin
        key_o = '0;
        if (state_q == VALID) begin
            key_o.valid = 1'b1;
            key_o.key   = store_key;
        end
    end

    assign word_ready_o = word_ready;
    assign busy_o       = (state_q == LOAD) || (state_q == WIPE);
    assign err_o        = err_q;

endmodule
